// File: rtl/param_shift_pipe.sv
// param_shift_pipe: WIDTH x DEPTH valid-tagged shift/rotate delay line with tap readout and occupancy count
module param_shift_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int SELW = $clog2(DEPTH),
  localparam int CNTW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic [SELW-1:0]  tap_sel,
  output logic [WIDTH-1:0] tap_data,
  output logic [CNTW-1:0]  fill,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [WIDTH-1:0] head_d;
  logic             head_v;
  logic             clear;
  logic [CNTW:0]    fill_nx;
  logic             fill_unused;
  always_comb begin
    clear   = mode == 2'b11;
    head_d  = mode == 2'b00 ? din : mode == 2'b01 ? data[DEPTH-1] : '0;
    head_v  = mode == 2'b00 ? din_valid : mode == 2'b01 ? vld[DEPTH-1] : 1'b0;
    // widened by one bit so the +din_valid step cannot wrap before truncation
    fill_nx = clear ? '0
            : mode == 2'b01 ? {1'b0, fill}
            : {1'b0, fill} + {{CNTW{1'b0}}, mode == 2'b00 && din_valid} - {{CNTW{1'b0}}, vld[DEPTH-1]};
  end
  assign fill_unused = fill_nx[CNTW];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) data[i] <= '0;
      vld  <= '0;
      fill <= '0;
    end else if (shift_en) begin
      data[0] <= clear ? '0 : head_d;
      for (int i = 1; i < DEPTH; i++) data[i] <= clear ? '0 : data[i-1];
      vld  <= clear ? '0 : {vld[DEPTH-2:0], head_v};
      fill <= fill_nx[CNTW-1:0];
    end
  end
  always_comb begin
    tap_data = '0;
    for (int i = 0; i < DEPTH; i++) if (tap_sel == SELW'(i)) tap_data = data[i];
  end
  assign dout       = data[DEPTH-1];
  assign dout_valid = vld[DEPTH-1];
  assign full       = fill == CNTW'(DEPTH);
  assign empty      = fill == '0;
endmodule

// File: tb/tb_param_shift_pipe.sv
// tb_param_shift_pipe: directed vectors with a queued scoreboard drained by a negedge monitor
module tb_param_shift_pipe;
  logic       clk = 0, rst = 1, shift_en = 0, din_valid = 0;
  logic [1:0] mode = 0;
  logic [7:0] din = 0;
  logic [1:0] tap_sel = 0;
  logic [2:0] tap5_sel = 7;
  logic [7:0] dout, tap_data, dout5, tap5_data;
  logic       dout_valid, full, empty, dout5_valid, full5, empty5;
  logic [2:0] fill, fill5;

  param_shift_pipe #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .shift_en(shift_en), .mode(mode), .din(din), .din_valid(din_valid),
    .dout(dout), .dout_valid(dout_valid), .tap_sel(tap_sel), .tap_data(tap_data),
    .fill(fill), .full(full), .empty(empty));

  param_shift_pipe #(.WIDTH(8), .DEPTH(5)) dut5 (
    .clk(clk), .rst(rst), .shift_en(shift_en), .mode(mode), .din(din), .din_valid(din_valid),
    .dout(dout5), .dout_valid(dout5_valid), .tap_sel(tap5_sel), .tap_data(tap5_data),
    .fill(fill5), .full(full5), .empty(empty5));

  always #10 clk = ~clk;

  typedef struct {string name; int sig; int sel; int val;} item_t;
  item_t q[$];
  int checks = 0, failures = 0;

  function automatic void expect_(string n, int sig, int sel, int val);
    q.push_back('{n, sig, sel, val});
  endfunction

  function automatic void exp_st(string n, int d, int dv, int f, int fu, int em);
    expect_({n, ".dout"}, 0, 0, d);
    expect_({n, ".dout_valid"}, 1, 0, dv);
    expect_({n, ".fill"}, 2, 0, f);
    expect_({n, ".full"}, 3, 0, fu);
    expect_({n, ".empty"}, 4, 0, em);
  endfunction

  function automatic void exp_taps(string n, int t0, int t1, int t2, int t3);
    expect_({n, ".tap0"}, 5, 0, t0);
    expect_({n, ".tap1"}, 5, 1, t1);
    expect_({n, ".tap2"}, 5, 2, t2);
    expect_({n, ".tap3"}, 5, 3, t3);
  endfunction

  // monitor: drains everything expected for this cycle, away from the rising edge
  always @(negedge clk) begin
    item_t it;
    int act;
    while (q.size() > 0) begin
      it = q.pop_front();
      act = 0;
      case (it.sig)
        0: act = int'(dout);
        1: act = int'(dout_valid);
        2: act = int'(fill);
        3: act = int'(full);
        4: act = int'(empty);
        5: begin tap_sel = it.sel[1:0]; #1 act = int'(tap_data); end
        default: begin tap5_sel = it.sel[2:0]; #1 act = int'(tap5_data); end
      endcase
      checks++;
      if (act != it.val) begin
        failures++;
        $display("FAIL %s: got %0h expected %0h", it.name, act, it.val);
      end
    end
  end

  task automatic cyc(input bit en, input bit [1:0] m, input bit [7:0] d, input bit dv);
    shift_en = en; mode = m; din = d; din_valid = dv;
    @(posedge clk);
    #2;
  endtask

  initial begin
    exp_st("reset", 0, 0, 0, 0, 1);
    @(posedge clk); @(posedge clk); #2 rst = 0;
    // fill to full, then overflow drops the oldest
    cyc(1, 0, 8'hA1, 1); cyc(1, 0, 8'hB2, 1); cyc(1, 0, 8'hC3, 1); cyc(1, 0, 8'hD4, 1);
    exp_st("load", 8'hA1, 1, 4, 1, 0);
    exp_taps("load", 8'hD4, 8'hC3, 8'hB2, 8'hA1);
    cyc(1, 0, 8'hE5, 1);
    exp_st("overflow", 8'hB2, 1, 4, 1, 0);
    expect_("d5.tap4", 6, 4, 8'hA1);
    expect_("d5.tap5", 6, 5, 0);
    expect_("d5.tap7", 6, 7, 0);
    // clear, reload, rotate
    cyc(1, 3, 8'h00, 0);
    exp_st("clear1", 0, 0, 0, 0, 1);
    exp_taps("clear1", 0, 0, 0, 0);
    cyc(1, 0, 8'hA1, 1); cyc(1, 0, 8'hB2, 1); cyc(1, 0, 8'hC3, 1); cyc(1, 0, 8'hD4, 1);
    cyc(1, 1, 8'hFF, 1);
    exp_st("rot1", 8'hB2, 1, 4, 1, 0);
    expect_("rot1.tap0", 5, 0, 8'hA1);
    expect_("rot1.tap1", 5, 1, 8'hD4);
    cyc(0, 3, 8'h00, 0);
    expect_("hold.fill", 2, 0, 4);
    expect_("hold.tap0", 5, 0, 8'hA1);
    cyc(1, 1, 8'h00, 0); cyc(1, 1, 8'h00, 0); cyc(1, 1, 8'h00, 0);
    exp_st("rot4", 8'hA1, 1, 4, 1, 0);
    exp_taps("rot4", 8'hD4, 8'hC3, 8'hB2, 8'hA1);
    // flush bubbles
    cyc(1, 2, 8'hFF, 1); cyc(1, 2, 8'hFF, 1);
    exp_st("flush2", 8'hC3, 1, 2, 0, 0);
    expect_("flush2.tap0", 5, 0, 0);
    cyc(1, 2, 8'h00, 0); cyc(1, 2, 8'h00, 0);
    exp_st("flush4", 0, 0, 0, 0, 1);
    cyc(1, 2, 8'h00, 0);
    exp_st("flush_empty", 0, 0, 0, 0, 1);
    // shifts interleaved with holds and an invalid entry, then clear
    cyc(1, 0, 8'hA1, 1);
    cyc(0, 0, 8'hFF, 1);
    expect_("mix.hold1", 2, 0, 1);
    cyc(1, 0, 8'hB2, 1);
    cyc(0, 2, 8'h00, 0);
    expect_("mix.hold2", 2, 0, 2);
    cyc(1, 0, 8'h33, 0);
    expect_("mix.invalid", 2, 0, 2);
    cyc(1, 0, 8'hC3, 1);
    exp_st("mix", 8'hA1, 1, 3, 0, 0);
    exp_taps("mix", 8'hC3, 8'h33, 8'hB2, 8'hA1);
    cyc(1, 3, 8'hFF, 1);
    exp_st("clear2", 0, 0, 0, 0, 1);
    exp_taps("clear2", 0, 0, 0, 0);
    // asynchronous reset between edges
    cyc(1, 0, 8'h11, 1); cyc(1, 0, 8'h22, 1); cyc(1, 0, 8'h33, 1); cyc(1, 0, 8'h44, 0);
    exp_st("pre_rst", 8'h11, 1, 3, 0, 0);
    cyc(0, 0, 8'h00, 0);
    #1 rst = 1;
    exp_st("async_rst", 0, 0, 0, 0, 1);
    expect_("async_rst.tap1", 5, 1, 0);
    expect_("async_rst.tap2", 5, 2, 0);
    @(posedge clk); #2 rst = 0;
    cyc(1, 0, 8'h55, 1);
    exp_st("post_rst", 0, 0, 1, 0, 0);
    expect_("post_rst.tap0", 5, 0, 8'h55);
    expect_("d5.post_tap0", 6, 0, 8'h55);
    expect_("d5.post_tap7", 6, 7, 0);
    cyc(0, 0, 8'h00, 0);
    @(negedge clk); @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
